// File: rtl/alu_seq.sv
// alu_seq: eight-op ALU with valid/ready handshakes and a WIDTH-cycle shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;
  logic [1:0] state;
  logic [WIDTH-1:0] mcand, hi, lo, sum, diff, res, mul_lo, mul_hi;
  logic [WIDTH:0] step_sum;
  logic [CW-1:0] cnt;
  logic accept, last, res_ovf;
  assign in_ready = !reset && (state == IDLE || (state == DONE && out_ready));
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign sum = A + B;
  assign diff = A - B;
  assign step_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign mul_lo = {step_sum[0], lo[WIDTH-1:1]};
  assign mul_hi = step_sum[WIDTH:1];
  assign last = cnt == CW'(WIDTH - 1);
  // single-cycle result and signed overflow for every non-multiply opcode
  always_comb begin
    res = '0;
    res_ovf = 1'b0;
    case (control)
      3'd1: res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      3'd2: begin
        res = sum;
        res_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'd3: begin
        res = diff;
        res_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      3'd4: res = A & B;
      3'd5: res = A | B;
      3'd6: res = ~(A | B);
      3'd7: res = A ^ B;
      default: res = '0;
    endcase
  end
  // handshake FSM; {hi,lo} shifts right one multiplier bit per MUL cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out <= '0;
      overflow <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      mcand <= '0;
    end else if (accept) begin
      if (control == 3'd0) begin
        state <= MUL;
        hi <= '0;
        lo <= B;
        mcand <= A;
        cnt <= '0;
      end else begin
        state <= DONE;
        out <= res;
        overflow <= res_ovf;
        zero <= res == '0;
        negative <= res[WIDTH-1];
      end
    end else if (state == MUL) begin
      hi <= mul_hi;
      lo <= mul_lo;
      cnt <= cnt + CW'(1);
      if (last) begin
        state <= DONE;
        out <= mul_lo;
        overflow <= |mul_hi;
        zero <= mul_lo == '0;
        negative <= mul_lo[WIDTH-1];
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule
